// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared limits and defaults for the serial sequence detector
package seq_detect_pkg;
    localparam int PAT_LEN_MIN   = 2;
    localparam int PAT_LEN_MAX   = 16;
    localparam int DEFAULT_CNT_W = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with clear taking priority over increment
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;
    // next count: clear wins, otherwise increment until all ones and stick there
    always_comb begin
        q_d = clr ? '0 : (inc && q_q != '1) ? q_q + 1'b1 : q_q;
    end
    // count register
    always_ff @(posedge clk) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/seq_detect_mealy.sv
// seq_detect_mealy: loadable-pattern serial Mealy detector with overlap mode and hit counter
module seq_detect_mealy
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN   = 4,
    parameter int                 CNT_W     = DEFAULT_CNT_W,
    parameter logic [PAT_LEN-1:0] RESET_PAT = PAT_LEN'(4'b1011)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               pat_load,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   hit_count
);
    localparam int              FW       = $clog2(PAT_LEN);
    localparam logic [FW-1:0]   FILL_MAX = FW'(PAT_LEN - 1);

    if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_pat_len
        $error("seq_detect_mealy: PAT_LEN out of range");
    end

    logic [PAT_LEN-1:0] pat_q, pat_d, win;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               match;

    // window = history plus current bit; a load or a non-overlapping hit flushes history
    always_comb begin
        win    = {hist_q, x};
        match  = x_valid & ~pat_load & (fill_q == FILL_MAX) & (win == pat_q);
        pat_d  = pat_load ? pat_in : pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (pat_load || (match && !overlap)) begin
            hist_d = '0;
            fill_d = '0;
        end else if (x_valid) begin
            hist_d = win[PAT_LEN-2:0];
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        end
    end

    // pattern, history and fill registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= RESET_PAT;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign z = match & ~reset;

    sat_counter #(.W(CNT_W)) u_hits (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (cnt_clr),
        .q     (hit_count)
    );
endmodule

// File: doc/seq_detect_mealy.md
Name: seq_detect_mealy

Overview:
Parametrised serial Mealy sequence detector. Generalises the 4-state hard-coded Mealy FSM to a run-time-loadable PAT_LEN-bit pattern with an overlap/non-overlap mode, a valid qualifier and a saturating hit counter. It sits behind a serial input stream. It flags each completed pattern on the same cycle as the last bit arrives (Mealy output) and keeps a running match count for software readback.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16
CNT_W, 8, width of hit counter
RESET_PAT, 4'b1011, pattern value held after reset; width PAT_LEN

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; one clock, synchronous active-high reset
x  input  1  serial data bit
x_valid  input  1  x is sampled only when 1
pat_in  input  PAT_LEN  new pattern; pat_in[PAT_LEN-1] is the first bit expected, pat_in[0] the last
pat_load  input  1  latch pat_in and flush history
overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping
cnt_clr  input  1  clear hit counter
z  output  1  Mealy match flag, combinational from state and current inputs
hit_count  output  CNT_W  saturating count of matches

Behaviour:
- State: pat_q[PAT_LEN-1:0], hist[PAT_LEN-2:0] (shift register, newest bit in [0]), fill (0..PAT_LEN-1, counts valid bits held in hist, saturates at PAT_LEN-1), hit_count.
- Reset (sync, on clk edge with reset=1): pat_q=RESET_PAT, hist=0, fill=0, hit_count=0. While reset=1, z=0. Reset has priority over every other input, including reset in the middle of a partial match.
- match = x_valid & ~pat_load & (fill==PAT_LEN-1) & ({hist,x}==pat_q).
- z = match & ~reset. This is the same-cycle Mealy output with zero latency, and it has no register.
- pat_load=1: pat_q<=pat_in, hist<=0, fill<=0. x is ignored that cycle and z=0. The new pattern applies to bits arriving on the next cycle.
- x_valid=1, no load, no match: hist<={hist[PAT_LEN-3:0],x} (for PAT_LEN=2 hist<=x), fill<=min(fill+1,PAT_LEN-1).
- On match with overlap=1: hist shifts in x as above and fill stays saturated, so a following bit can complete a new match.
- On match with overlap=0: hist<=0 and fill<=0, so the next match needs PAT_LEN fresh bits.
- overlap is sampled only on the match cycle. Changing it mid-stream has no other effect.
- x_valid=0: hist, fill and pat_q hold, and z=0. Gaps in valid do not break a partial match.
- hit_count: on match, +1, saturating at 2^CNT_W-1 (no wrap). cnt_clr=1 sets it to 0. If cnt_clr and match occur in the same cycle, the clear wins and hit_count=0. cnt_clr does not affect hist or fill.
- All registered outputs are glitch-free. z is combinational by design, so a consumer registers it.

Decomposition:
- Shared package seq_detect_pkg holds PAT_LEN_MIN=2, PAT_LEN_MAX=16 and DEFAULT_CNT_W=8. The RTL carries an elaboration-time check that PAT_LEN is within range.
- One natural sub-module, sat_counter (params W; ports clk, reset, inc, clr, q), implements hit_count with clear-over-increment priority and saturation. It is reusable by other status counters.
- The shift/compare window stays inline in seq_detect_mealy.

Test Plan:
1. PAT_LEN=4, reset pattern 1011, overlap=1, x_valid=1, stream 1,0,1,1,0,1,1 -> z=1 on bit 4 and bit 7 (the same cycles those bits are presented), hit_count=2.
2. Same stream with overlap=0 -> z=1 on bit 4 only, hit_count=1. Then stream 1,0,1,1 -> z on its 4th bit, hit_count=2.
3. Stream 1,0,1 then x_valid=0 for 3 cycles, then x=1 valid -> z=1 on that valid bit, and z=0 throughout the gap.
4. pat_load with pat_in=0110 on the same cycle as x_valid=1 and x=1 completing 1011 -> z=0 with no count. The following stream 0,1,1,0 -> z=1 on 4th bit.
5. CNT_W=2: drive 5 overlapping matches of 1111 (stream of eight 1s) -> hit_count saturates at 3 with no wrap. cnt_clr asserted together with a match cycle -> hit_count=0.
6. Stream 1,0,1, assert reset 1 cycle, then bit 1 -> z=0 (history flushed). Then 0,1,1 -> z=1 on the final bit, pattern equal to RESET_PAT, hit_count=1.
